// File: rtl/pong_pkg.sv
// Shared definitions for the pong ball engine: FSM encoding and default field geometry.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_SCORED = 2'd3
  } pong_state_e;

  localparam int COORD_W         = 10;
  localparam int DEF_H_RES       = 640;
  localparam int DEF_V_RES       = 480;
  localparam int DEF_BALL_SZ     = 8;
  localparam int DEF_PAD_H       = 64;
  localparam int DEF_PAD_X_L     = 24;
  localparam int DEF_PAD_X_R     = 616;
  localparam int DEF_SPD_W       = 3;
  localparam int DEF_SCORE_W     = 4;
  localparam int DEF_WIN_SCORE   = 11;
  localparam int DEF_HOLD_FRAMES = 60;

  // Top-left coordinate that centres a ball of side sz on an axis of length res.
  function automatic int centre(input int res, input int sz);
    return (res - sz) / 2;
  endfunction

endpackage

// File: rtl/pong_score_ctr.sv
// Saturating per-player scores plus the post-point hold timer.
module pong_score_ctr
  import pong_pkg::*;
#(
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               inc_l,
  input  logic               inc_r,
  input  logic               hold_load,
  input  logic               hold_tick,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               win,
  output logic               hold_last
);

  localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
  localparam logic [HW-1:0]      HOLD_VAL = HW'(HOLD_FRAMES);

  logic [HW-1:0] hold_cnt;

  // Hold timer: loaded when a point is scored, counts frame ticks down to terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (hold_load) begin
      hold_cnt <= HOLD_VAL;
    end else if (hold_tick && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // The tick that sees a count of one is the last frame of the hold.
  assign hold_last = (hold_cnt <= HW'(1));

  // Scores stop at WIN_SCORE so they can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_l <= '0;
      score_r <= '0;
    end else if (clear) begin
      score_l <= '0;
      score_r <= '0;
    end else begin
      if (inc_l && (score_l != WIN_VAL)) score_l <= score_l + SCORE_W'(1);
      if (inc_r && (score_r != WIN_VAL)) score_r <= score_r + SCORE_W'(1);
    end
  end

  assign win = (score_l == WIN_VAL) || (score_r == WIN_VAL);

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball engine: per-frame ball motion, wall/paddle reflection and point scoring.
//
// state  | meaning
// IDLE   | waiting for serve; game_over stays set after a finished match
// SERVE  | ball parked at field centre until the next frame tick
// PLAY   | ball steps once per frame tick, bouncing off walls and paddles
// SCORED | ball frozen for HOLD_FRAMES frame ticks after a point
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int BALL_SZ     = DEF_BALL_SZ,
  parameter int PAD_H       = DEF_PAD_H,
  parameter int PAD_X_L     = DEF_PAD_X_L,
  parameter int PAD_X_R     = DEF_PAD_X_R,
  parameter int SPD_W       = DEF_SPD_W,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               serve,
  input  logic [SPD_W-1:0]   speed,
  input  logic [9:0]         pad_l_y,
  input  logic [9:0]         pad_r_y,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               point,
  output logic               game_over,
  output logic [1:0]         state
);

  localparam int CW = COORD_W;
  // Two guard bits so paddle_y + PAD_H and ball + size + step never overflow.
  localparam int XW = CW + 2;

  localparam logic [CW-1:0] X_CTR = CW'(centre(H_RES, BALL_SZ));
  localparam logic [CW-1:0] Y_CTR = CW'(centre(V_RES, BALL_SZ));
  localparam logic [XW-1:0] X_MAX = XW'(H_RES - BALL_SZ);
  localparam logic [XW-1:0] Y_MAX = XW'(V_RES - BALL_SZ);
  localparam logic [XW-1:0] SZ    = XW'(BALL_SZ);
  localparam logic [XW-1:0] PH    = XW'(PAD_H);
  localparam logic [XW-1:0] PXL   = XW'(PAD_X_L);
  localparam logic [XW-1:0] PXR   = XW'(PAD_X_R);

  pong_state_e   state_q;
  logic [CW-1:0] ball_x_q, ball_y_q;
  logic          dir_x_q, dir_y_q;
  logic          point_q, game_over_q;

  logic [XW-1:0] step, bx, by, pl, pr;
  logic [CW-1:0] x_nxt, y_nxt;
  logic          dx_nxt, dy_nxt;
  logic          ov_l, ov_r;
  logic          miss_r, miss_l;

  logic          play_tick, pt_l, pt_r, score_clear, hold_tick;
  logic          win, hold_last;

  assign step = (speed == '0) ? XW'(1) : XW'(speed);
  assign bx   = XW'(ball_x_q);
  assign by   = XW'(ball_y_q);
  assign pl   = XW'(pad_l_y);
  assign pr   = XW'(pad_r_y);

  // Candidate next position for one frame; X and Y resolve independently.
  always_comb begin
    y_nxt  = ball_y_q;
    dy_nxt = dir_y_q;
    x_nxt  = ball_x_q;
    dx_nxt = dir_x_q;
    miss_r = 1'b0;
    miss_l = 1'b0;

    // Overlap uses the position before this frame's Y step.
    ov_l = ((by + SZ) > pl) && (by < (pl + PH));
    ov_r = ((by + SZ) > pr) && (by < (pr + PH));

    if (dir_y_q) begin
      if ((by + step) >= Y_MAX) begin
        y_nxt  = CW'(Y_MAX);
        dy_nxt = 1'b0;
      end else begin
        y_nxt = CW'(by + step);
      end
    end else begin
      if (by <= step) begin
        y_nxt  = '0;
        dy_nxt = 1'b1;
      end else begin
        y_nxt = CW'(by - step);
      end
    end

    // On a miss the ball keeps its X; the frozen SCORED frame shows where it left play.
    if (dir_x_q) begin
      if (((bx + SZ + step) >= PXR) && ov_r) begin
        x_nxt  = CW'(PXR - SZ);
        dx_nxt = 1'b0;
      end else if ((bx + step) >= X_MAX) begin
        miss_r = 1'b1;
      end else begin
        x_nxt = CW'(bx + step);
      end
    end else begin
      if ((bx <= (PXL + step)) && ov_l) begin
        x_nxt  = CW'(PXL);
        dx_nxt = 1'b1;
      end else if (bx <= step) begin
        miss_l = 1'b1;
      end else begin
        x_nxt = CW'(bx - step);
      end
    end
  end

  assign play_tick   = (state_q == ST_PLAY) && frame_tick;
  assign pt_l        = play_tick && miss_r;
  assign pt_r        = play_tick && miss_l;
  assign hold_tick   = (state_q == ST_SCORED) && frame_tick;
  assign score_clear = (state_q == ST_IDLE) && serve && game_over_q;

  pong_score_ctr #(
    .SCORE_W    (SCORE_W),
    .WIN_SCORE  (WIN_SCORE),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_score_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (score_clear),
    .inc_l    (pt_l),
    .inc_r    (pt_r),
    .hold_load(pt_l | pt_r),
    .hold_tick(hold_tick),
    .score_l  (score_l),
    .score_r  (score_r),
    .win      (win),
    .hold_last(hold_last)
  );

  // Main FSM with registered ball, direction, point and game_over outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= X_CTR;
      ball_y_q    <= Y_CTR;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      point_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      point_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (serve) begin
            state_q     <= ST_SERVE;
            ball_x_q    <= X_CTR;
            ball_y_q    <= Y_CTR;
            game_over_q <= 1'b0;
          end
        end
        ST_SERVE: begin
          ball_x_q <= X_CTR;
          ball_y_q <= Y_CTR;
          if (frame_tick) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          if (frame_tick) begin
            ball_x_q <= x_nxt;
            ball_y_q <= y_nxt;
            dir_x_q  <= dx_nxt;
            dir_y_q  <= dy_nxt;
            // dir_x already points at the conceding side, so the next serve heads there.
            if (miss_r || miss_l) begin
              point_q <= 1'b1;
              state_q <= ST_SCORED;
            end
          end
        end
        ST_SCORED: begin
          if (frame_tick && hold_last) begin
            if (win) begin
              state_q     <= ST_IDLE;
              game_over_q <= 1'b1;
            end else begin
              state_q  <= ST_SERVE;
              ball_x_q <= X_CTR;
              ball_y_q <= Y_CTR;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign dir_x     = dir_x_q;
  assign dir_y     = dir_y_q;
  assign point     = point_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: directed scenarios plus randomized play,
// every cycle compared against a frame-level behavioural model of the game rules.
module tb_pong_ball_engine;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int SZ = 8;
  localparam int PH = 64;
  localparam int XL = 24;
  localparam int XR = 616;
  localparam int WIN  = 11;
  localparam int HOLD = 60;
  localparam int CX = (H - SZ) / 2;
  localparam int CY = (V - SZ) / 2;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       serve;
  logic [2:0] speed;
  logic [9:0] pad_l_y, pad_r_y;
  logic [9:0] ball_x, ball_y;
  logic       dir_x, dir_y;
  logic [3:0] score_l, score_r;
  logic       point, game_over;
  logic [1:0] state;

  pong_ball_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .serve     (serve),
    .speed     (speed),
    .pad_l_y   (pad_l_y),
    .pad_r_y   (pad_r_y),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .dir_x     (dir_x),
    .dir_y     (dir_y),
    .score_l   (score_l),
    .score_r   (score_r),
    .point     (point),
    .game_over (game_over),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: 0 idle, 1 waiting serve tick, 2 in play, 3 point hold.
  int m_st, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_go, m_pt, m_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1;
    m_sl = 0; m_sr = 0; m_go = 0; m_pt = 0; m_hold = 0;
  endtask

  task automatic model_step(input bit sv, input bit tk, input int spd, input int pl, input int pr);
    int  s, ny, ndy;
    bit  ovl, ovr;
    m_pt = 0;
    s = (spd == 0) ? 1 : spd;
    if (m_st == 0) begin
      if (sv) begin
        if (m_go == 1) begin m_sl = 0; m_sr = 0; m_go = 0; end
        m_st = 1; m_bx = CX; m_by = CY;
      end
    end else if (m_st == 1) begin
      if (tk) m_st = 2;
    end else if (m_st == 2) begin
      if (tk) begin
        ovl = (m_by + SZ > pl) && (m_by < pl + PH);
        ovr = (m_by + SZ > pr) && (m_by < pr + PH);
        ny = m_by; ndy = m_dy;
        if (m_dy == 1) begin
          if (m_by + s >= V - SZ) begin ny = V - SZ; ndy = 0; end
          else ny = m_by + s;
        end else begin
          if (m_by <= s) begin ny = 0; ndy = 1; end
          else ny = m_by - s;
        end
        if (m_dx == 1) begin
          if (m_bx + SZ + s >= XR && ovr) begin m_bx = XR - SZ; m_dx = 0; end
          else if (m_bx + s >= H - SZ) begin
            if (m_sl < WIN) m_sl++;
            m_pt = 1; m_st = 3; m_hold = 0;
          end else m_bx = m_bx + s;
        end else begin
          if (m_bx <= XL + s && ovl) begin m_bx = XL; m_dx = 1; end
          else if (m_bx <= s) begin
            if (m_sr < WIN) m_sr++;
            m_pt = 1; m_st = 3; m_hold = 0;
          end else m_bx = m_bx - s;
        end
        m_by = ny; m_dy = ndy;
      end
    end else begin
      if (tk) begin
        m_hold++;
        if (m_hold == HOLD) begin
          if (m_sl == WIN || m_sr == WIN) begin m_st = 0; m_go = 1; end
          else begin m_st = 1; m_bx = CX; m_by = CY; end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(state), m_st);
    chk("ball_x", 32'(ball_x), m_bx);
    chk("ball_y", 32'(ball_y), m_by);
    chk("dir_x", 32'(dir_x), m_dx);
    chk("dir_y", 32'(dir_y), m_dy);
    chk("score_l", 32'(score_l), m_sl);
    chk("score_r", 32'(score_r), m_sr);
    chk("point", 32'(point), m_pt);
    chk("game_over", 32'(game_over), m_go);
  endtask

  task automatic cyc(input bit sv, input bit tk);
    serve = sv;
    frame_tick = tk;
    model_step(sv, tk, int'(speed), int'(pad_l_y), int'(pad_r_y));
    @(posedge clk);
    #1;
    serve = 1'b0;
    frame_tick = 1'b0;
    compare_all();
  endtask

  task automatic tick();
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must change without any edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; serve = 1'b0; frame_tick = 1'b0;
    speed = 3'd2; pad_l_y = 10'd0; pad_r_y = 10'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Idle: frame ticks do nothing.
    for (int i = 0; i < 10; i++) tick();
    chk("idle_state", 32'(state), 0);
    chk("idle_x", 32'(ball_x), 316);
    chk("idle_y", 32'(ball_y), 236);

    // Serve then two ticks at speed 2.
    cyc(1'b1, 1'b0);
    chk("serve_state", 32'(state), 1);
    tick();
    tick();
    chk("play_state", 32'(state), 2);
    chk("play_x", 32'(ball_x), 318);
    chk("play_y", 32'(ball_y), 238);
    cyc(1'b1, 1'b0);
    chk("serve_ignored", 32'(state), 2);
    tick();
    do_reset();
    chk("rst_play_state", 32'(state), 0);
    chk("rst_play_x", 32'(ball_x), 316);

    // Bottom wall bounce then miss on the right.
    speed = 3'd4; pad_r_y = 10'd0; pad_l_y = 10'd200;
    cyc(1'b1, 1'b0);
    tick();
    for (int k = 1; k <= 79; k++) begin
      cyc(1'b0, 1'b1);
      if (k == 58) chk("pre_bounce_dir_y", 32'(dir_y), 1);
      if (k == 59) begin
        chk("bounce_dir_y", 32'(dir_y), 0);
        chk("bounce_y", 32'(ball_y), 472);
      end
      if (k == 78) chk("no_point_yet", 32'(point), 0);
      if (k == 79) begin
        chk("miss_point", 32'(point), 1);
        chk("miss_score_l", 32'(score_l), 1);
        chk("miss_state", 32'(state), 3);
      end
      cyc(1'b0, 1'b0);
    end
    chk("point_one_cycle", 32'(point), 0);
    tick();
    do_reset();
    chk("rst_scored_point", 32'(point), 0);
    chk("rst_scored_score", 32'(score_l), 0);

    // Right paddle hit.
    speed = 3'd4; pad_r_y = 10'd384;
    cyc(1'b1, 1'b0);
    tick();
    for (int k = 1; k <= 73; k++) begin
      cyc(1'b0, 1'b1);
      if (k == 73) begin
        chk("hit_x", 32'(ball_x), 608);
        chk("hit_dir_x", 32'(dir_x), 0);
        chk("hit_no_point", 32'(point), 0);
      end
      cyc(1'b0, 1'b0);
    end
    do_reset();

    // Full match: left player scores every rally.
    speed = 3'd4; pad_r_y = 10'd1000;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 4000 && m_sl < 10; i++) tick();
    chk("match_score_10", 32'(score_l), 10);
    for (int i = 0; i < 400 && m_pt == 0; i++) cyc(1'b0, 1'b1);
    chk("match_point", 32'(point), 1);
    chk("match_score_11", 32'(score_l), 11);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < HOLD; i++) begin
      if (i == HOLD - 1) chk("hold_before_end", 32'(state), 3);
      tick();
    end
    chk("over_state", 32'(state), 0);
    chk("over_flag", 32'(game_over), 1);
    tick();
    chk("over_ticks_ignored", 32'(state), 0);
    cyc(1'b1, 1'b1);
    chk("restart_state", 32'(state), 1);
    chk("restart_score_l", 32'(score_l), 0);
    chk("restart_over", 32'(game_over), 0);
    chk("restart_dir_x", 32'(dir_x), 1);

    // Randomized play against the model.
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      speed = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) pad_l_y = 10'($urandom_range(0, 420));
      if ($urandom_range(0, 15) == 0) pad_r_y = 10'($urandom_range(0, 420));
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
